mul16_seq_ctrl: RTL
===================

Name: mul16_seq_ctrl

Overview:
Sequential 16x16 unsigned shift-and-add multiplier: control FSM, step counter, 32-bit accumulator, and window adder. Each step reads a 16-bit window of the accumulator through an internal overlap_extractor instance (acc, clk1 = step count). When the multiplier bit is set, the step adds the multiplicand to that window and writes the 17-bit sum back into the accumulator. This block is the consumer of acc_part and the producer of acc for that extractor.

Parameters:
- N_STEPS, 16, number of multiplier bits and step cycles; fixed at 16 to match the 4-bit step index.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a  in  16  multiplicand, captured when start is accepted
- b  in  16  multiplier, captured when start is accepted
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse; product valid
- r  out  32  product; held from done until the next accepted start
- step  out  4  current step index (clk1 to the extractor)

Behaviour:
- Reset (reset=1 at an edge, in any state, including mid-operation):
  - state=IDLE; acc, a_reg, b_reg, step, r all 0; busy=0; done=0.
  - Any in-flight result is discarded.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge n:
  - a_reg<=a, b_reg<=b, acc<=0, step<=0, state<=RUN.
- IDLE, start=0: hold; r keeps its last value.
- RUN, each edge (step k = 0..15):
  - If b_reg[k]=1: acc[k+16:k] <= {1'b0,acc_part} + {1'b0,a_reg} (17-bit sum, carry kept). acc_part = acc[k+15:k].
  - If b_reg[k]=0: acc unchanged.
  - Bits of acc outside [k+16:k] are never modified.
  - k<15: step<=k+1.
  - k=15: state<=DONE, r<=final acc value (including the step-15 add), step<=0.
- Write at k=15 covers acc[31:15]. The product is bit-exact unsigned a*b; no overflow is possible.
- DONE: done=1 for exactly one cycle; next edge state<=IDLE.
- Latency: start sampled at edge n; steps at edges n+1..n+16; done high in the cycle after edge n+16.
- Throughput: a new start is accepted at the earliest in IDLE, 18 cycles after the previous start.
- start in RUN or DONE: ignored, with no effect on the operation in flight.
- Inputs a and b may change freely after acceptance; only a_reg and b_reg are used.
- busy=1 exactly in RUN; done and busy are never high together.
- Outputs are registered; no combinational path from start to any output.

Optional Feature:
- Macro: MUL16_EARLY_TERM_EN.
- Defined:
  - After step k, if b_reg[15:k+1]==0 (or k=15), transition to DONE and latch r.
  - Result is identical; latency is (index of the highest set bit of b, or 0 if b=0) + 1 steps.
- Undefined: always exactly 16 steps; fixed latency as above.

Test Plan:
- a=3, b=5, start at edge n -> done pulses in the cycle after edge n+16; r=0x0000000F; busy high for 16 cycles.
- a=0xFFFF, b=0xFFFF -> r=0xFFFE0001 (carry propagation into acc[31]); done one cycle wide.
- a=0x8000, b=0x0002 -> r=0x00010000; then a=0, b=0x1234 -> r=0x00000000.
- Start accepted with a=7, b=9; start re-pulsed with a=1, b=1 during RUN -> ignored, r=0x0000003F.
- reset asserted at step 8 of a=0xFFFF, b=0xFFFF -> next cycle state IDLE, r=0, busy=0, no done.
- With MUL16_EARLY_TERM_EN: a=7, b=1 -> done after 1 step, r=7.
- With MUL16_EARLY_TERM_EN: a=2, b=0x0100 -> done after 9 steps, r=0x200.
- Without MUL16_EARLY_TERM_EN: the same two cases take 16 steps with the same r.

Source files
------------

// File: rtl/mul16_seq_ctrl.sv
// Sequential 16x16 unsigned shift-and-add multiplier with a sliding 16-bit accumulator window.
// Optional macro MUL16_EARLY_TERM_EN: finish as soon as no set multiplier bits remain.

module overlap_extractor (
  input  logic [31:0] acc,
  input  logic [3:0]  clk1,
  output logic [15:0] acc_part
);
  assign acc_part = acc[clk1 +: 16];
endmodule

module mul16_seq_ctrl #(
  parameter int unsigned N_STEPS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] r,
  output logic [3:0]  step
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_n;
  logic [31:0] acc, acc_n;
  logic [15:0] a_reg, b_reg;
  logic [15:0] acc_part;
  logic [16:0] sum;
  logic        last;

  overlap_extractor u_extract (
    .acc      (acc),
    .clk1     (step),
    .acc_part (acc_part)
  );

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_comb begin
    sum   = {1'b0, acc_part} + {1'b0, a_reg};
    acc_n = acc;
    if (b_reg[step])
      acc_n[step +: 17] = sum;
`ifdef MUL16_EARLY_TERM_EN
    last = (step == 4'(N_STEPS - 1)) || (((b_reg >> step) >> 1) == '0);
`else
    last = (step == 4'(N_STEPS - 1));
`endif
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last)  state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      a_reg <= '0;
      b_reg <= '0;
      step  <= '0;
      r     <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          a_reg <= a;
          b_reg <= b;
          acc   <= '0;
          step  <= '0;
        end
        RUN: begin
          acc <= acc_n;
          if (last) begin
            r    <= acc_n;
            step <= '0;
          end else begin
            step <= step + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
